alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencer and register-file front end for the 8-bit combinational ALU. It accepts one command at a time over a valid/ready handshake and reads two operands from a small internal register file. It drives the ALU's A/B/opcode inputs, samples the result and flags, writes back to the register file, and holds a flag register. It sits between the command source (testbench or future control FSM) and the ALU instance.

## Interface
- REG_AW, 2, register-file address width; depth = 2**REG_AW, 8 bits per entry
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (IDLE only)
- cmd_op  in  4  ALU opcode (0001..1001 valid)
- cmd_ra / cmd_rb / cmd_rd  in  REG_AW  operand A, operand B and destination addresses
- cmd_imm  in  8  immediate operand (see Configuration)
- cmd_imm_sel  in  1  select cmd_imm as B (see Configuration)
- reg_we  in  1  direct register load strobe
- reg_waddr  in  REG_AW  direct load address
- reg_wdata  in  8  direct load data
- dbg_addr  in  REG_AW  combinational read address
- dbg_data  out  8  regfile[dbg_addr]
- alu_a, alu_b  out  8  registered ALU operands
- alu_opcode  out  4  registered ALU opcode; 0000 when not in EXEC
- alu_y  in  8  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags
- done  out  1  one-cycle pulse at command completion
- err  out  1  qualifies done: command rejected
- flags  out  4  stored {N,Z,C,V}

## Operation
- States: IDLE, READ, EXEC, WRITE, ERR.
- IDLE: cmd_ready=1. Handshake is cmd_valid&cmd_ready. The command is latched. A valid op goes to READ; an invalid op (0000, 1010–1111) goes to ERR.
- READ: alu_a<=reg[ra]; alu_b<=reg[rb] (or imm); alu_opcode<=op → EXEC.
- EXEC: alu_y and the flags are sampled into holding registers at the end of the cycle → WRITE.
- WRITE: reg[rd]<=held result; flags<=held {N,Z,C,V}. V is stored as 0 unless op is 1000/1001. C is stored as delivered by the ALU. done=1. Next state is IDLE.
- ERR: done=1, err=1. No writeback and flags are unchanged. Next state is IDLE.
- Direct load: reg_we is honoured only in IDLE and ignored otherwise. A load in the same cycle as a command accept is written first. The command's READ sees the loaded value.
- Commands are strictly serialized, so there are no read/write hazards. rd may equal ra or rb.
- All arithmetic is 8-bit and wraps. Shift amounts use all 8 bits of B.

## Timing
- Accept at cycle T. READ is T+1, EXEC is T+2, WRITE/done is T+3, and the result is visible on dbg_data at T+4. cmd_ready is high again at T+4.
- Invalid op: ERR/done/err at T+1, cmd_ready at T+2.
- Maximum throughput is one command per 4 cycles. cmd_ready is low in READ, EXEC, WRITE and ERR. Commands presented then are held by the source and are not lost.
- Reset values: state=IDLE, cmd_ready=1, all registers 0x00, flags=0000, alu_a=alu_b=0x00, alu_opcode=0000, done=0, err=0.
- Reset in any state takes effect at the next edge: no writeback, no done pulse, and the in-flight command is discarded.
- done and err are never high for more than one cycle.

## Configuration
- ALUSEQ_IMM_EN defined: cmd_imm_sel=1 at accept latches cmd_imm as operand B instead of reg[rb].
- ALUSEQ_IMM_EN undefined: the cmd_imm and cmd_imm_sel ports remain but are ignored, and B is always reg[rb].

## Test plan
- ADD with overflow: load r0=0x7F, r1=0x01, op 1000, ra=0, rb=1, rd=2. Required: done at T+3, r2=0x80, flags N=1 Z=0 C=0 V=1.
- SUB to zero and borrow: r0=r1=0x05, op 1001 gives 0x00 with Z=1, N=0, V=0. Then r3=0x00, r1=0x01, op 1001, ra=3, rb=1 gives 0xFF with N=1, C=1.
- Invalid op: op 1010 gives done=err=1 at T+1. Registers and flags are unchanged and cmd_ready=1 at T+2.
- Back-to-back: cmd_valid held with 3 queued AND/OR/XOR commands. Required: accepts at T, T+4, T+8, cmd_ready low between accepts, results correct.
- Mid-operation reset: reset asserted during EXEC. Required: IDLE next cycle, cmd_ready=1, all registers and flags 0, no done pulse.
- Immediate (ALUSEQ_IMM_EN defined): r0=0x80, op 0110, cmd_imm=0x02, cmd_imm_sel=1 gives rd=0xE0 with N=1. Without the macro, the same stimulus with r1=0x01, rb=1 gives 0xC0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer and register file in front of the 8-bit ALU.
// Define ALUSEQ_IMM_EN to let cmd_imm replace reg[rb] as operand B.
module alu_seq_ctrl #(
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_ra,
   input  logic [REG_AW-1:0] cmd_rb,
   input  logic [REG_AW-1:0] cmd_rd,
   input  logic [7:0]        cmd_imm,
   input  logic              cmd_imm_sel,
   input  logic              reg_we,
   input  logic [REG_AW-1:0] reg_waddr,
   input  logic [7:0]        reg_wdata,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [7:0]        dbg_data,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_opcode,
   input  logic [7:0]        alu_y,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic              done,
   output logic              err,
   output logic [3:0]        flags
);
   localparam int DEPTH = 2 ** REG_AW;
   typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, ERR} state_t;
   state_t            state_q;
   logic [7:0]        regs_q [DEPTH];
   logic [3:0]        op_q, alu_op_q, nzcv_q, flags_q;
   logic [REG_AW-1:0] ra_q, rb_q, rd_q;
   logic [7:0]        alu_a_q, alu_b_q, y_q, b_sel;
   logic              done_q, err_q, op_ok;
   assign op_ok = cmd_op != 4'd0 && cmd_op <= 4'd9;
`ifdef ALUSEQ_IMM_EN
   logic [7:0] imm_q;
   logic       imm_sel_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         imm_q     <= '0;
         imm_sel_q <= 1'b0;
      end else if (state_q == IDLE && cmd_valid) begin
         imm_q     <= cmd_imm;
         imm_sel_q <= cmd_imm_sel;
      end
   end
   assign b_sel = imm_sel_q ? imm_q : regs_q[rb_q];
`else
   logic unused_imm;
   assign unused_imm = ^{cmd_imm, cmd_imm_sel};
   assign b_sel = regs_q[rb_q];
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         op_q     <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         y_q      <= '0;
         nzcv_q   <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // a direct load lands before the accepted command's READ
               if (reg_we) regs_q[reg_waddr] <= reg_wdata;
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  ra_q    <= cmd_ra;
                  rb_q    <= cmd_rb;
                  rd_q    <= cmd_rd;
                  state_q <= op_ok ? READ : ERR;
                  done_q  <= !op_ok;
                  err_q   <= !op_ok;
               end
            end
            READ: begin
               alu_a_q  <= regs_q[ra_q];
               alu_b_q  <= b_sel;
               alu_op_q <= op_q;
               state_q  <= EXEC;
            end
            EXEC: begin
               y_q      <= alu_y;
               nzcv_q   <= {alu_n, alu_z, alu_c, alu_v && (op_q == 4'd8 || op_q == 4'd9)};
               alu_op_q <= '0;
               done_q   <= 1'b1;
               state_q  <= WRITE;
            end
            WRITE: begin
               regs_q[rd_q] <= y_q;
               flags_q      <= nzcv_q;
               state_q      <= IDLE;
            end
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign cmd_ready  = state_q == IDLE;
   assign dbg_data   = regs_q[dbg_addr];
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign done       = done_q;
   assign err        = err_q;
   assign flags      = flags_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of alu_seq_ctrl driving a behavioural ALU stand-in.
module tb_alu_seq_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [3:0] cmd_op = '0;
   logic [1:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
   logic [7:0] cmd_imm = '0;
   logic       cmd_imm_sel = 1'b0;
   logic       reg_we = 1'b0;
   logic [1:0] reg_waddr = '0, dbg_addr = '0;
   logic [7:0] reg_wdata = '0, dbg_data;
   logic [7:0] alu_a, alu_b, alu_y;
   logic [3:0] alu_opcode, flags;
   logic       alu_n, alu_z, alu_c, alu_v, done, err;
   int         total = 0, bad = 0;
   logic [3:0] q_op [3] = '{4'd1, 4'd2, 4'd3};
   logic [1:0] q_ra [3] = '{2'd0, 2'd0, 2'd2};
   logic [1:0] q_rb [3] = '{2'd1, 2'd1, 2'd3};
   logic [1:0] q_rd [3] = '{2'd2, 2'd3, 2'd0};
   int         acc [3];
`ifdef ALUSEQ_IMM_EN
   localparam logic [7:0] IMM_B = 8'h02, IMM_Y = 8'hE0;
`else
   localparam logic [7:0] IMM_B = 8'h01, IMM_Y = 8'hC0;
`endif

   always #5 clk = ~clk;

   alu_seq_ctrl #(.REG_AW(2)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .cmd_imm(cmd_imm), .cmd_imm_sel(cmd_imm_sel), .reg_we(reg_we),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .done(done), .err(err), .flags(flags)
   );

   // ALU stand-in; logic ops raise V on purpose so the sequencer's V masking is visible
   logic [8:0] sum;
   always_comb begin
      sum   = '0;
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b1;
      case (alu_opcode)
         4'd1: alu_y = alu_a & alu_b;
         4'd2: alu_y = alu_a | alu_b;
         4'd3: alu_y = alu_a ^ alu_b;
         4'd4: alu_y = ~alu_a;
         4'd5: alu_y = alu_a << alu_b;
         4'd6: alu_y = 8'($signed(alu_a) >>> alu_b);
         4'd7: alu_y = alu_a >> alu_b;
         4'd8: begin
            sum   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_y = sum[7:0];
            alu_c = sum[8];
            alu_v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         4'd9: begin
            alu_y = alu_a - alu_b;
            alu_c = alu_a < alu_b;
            alu_v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         default: alu_y = '0;
      endcase
   end
   assign alu_n = alu_y[7];
   assign alu_z = alu_y == 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_check(input string tag, input logic [1:0] a, input logic [7:0] e);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, e);
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      reg_we = 1'b1;
      reg_waddr = a;
      reg_wdata = d;
      tick();
      reg_we = 1'b0;
   endtask

   task automatic do_cmd(input logic [3:0] op, input logic [1:0] ra, rb, rd,
                         input logic [7:0] imm, input logic sel, input logic [7:0] ea, eb);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_pre", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
      cmd_imm = imm; cmd_imm_sel = sel;
      tick();
      cmd_valid = 1'b0; cmd_imm_sel = 1'b0; reg_we = 1'b0;
      check("busy_t1", cmd_ready, 0);
      check("done_t1", done, 0);
      tick();
      check("op_exec", alu_opcode, op);
      check("a_exec", alu_a, ea);
      check("b_exec", alu_b, eb);
      check("done_t2", done, 0);
      tick();
      check("done_t3", done, 1);
      check("err_t3", err, 0);
      check("op_cleared", alu_opcode, 0);
      tick();
      check("done_t4", done, 0);
      check("ready_t4", cmd_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, cyc;
      tick();
      tick();
      reset = 1'b0;
      check("rst_ready", cmd_ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_flags", flags, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_opcode", alu_opcode, 0);
      for (int i = 0; i < 4; i++) reg_check("rst_reg", 2'(i), 8'h00);

      // ADD overflow; r1 is loaded in the same cycle the command is accepted
      load(2'd0, 8'h7F);
      reg_we = 1'b1; reg_waddr = 2'd1; reg_wdata = 8'h01;
      do_cmd(4'd8, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 8'h7F, 8'h01);
      reg_check("add_r2", 2'd2, 8'h80);
      check("add_flags", flags, 4'b1001);

      load(2'd0, 8'h05);
      load(2'd1, 8'h05);
      do_cmd(4'd9, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 8'h05, 8'h05);
      reg_check("sub0_r2", 2'd2, 8'h00);
      check("sub0_flags", flags, 4'b0100);

      load(2'd3, 8'h00);
      load(2'd1, 8'h01);
      do_cmd(4'd9, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, 8'h00, 8'h01);
      reg_check("borrow_r2", 2'd2, 8'hFF);
      check("borrow_flags", flags, 4'b1010);

      // invalid op; a direct load attempted while in ERR must be dropped
      cmd_valid = 1'b1; cmd_op = 4'b1010; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2;
      tick();
      cmd_valid = 1'b0;
      check("inv_done", done, 1);
      check("inv_err", err, 1);
      check("inv_busy", cmd_ready, 0);
      reg_we = 1'b1; reg_waddr = 2'd0; reg_wdata = 8'h55;
      tick();
      reg_we = 1'b0;
      check("inv_done_clr", done, 0);
      check("inv_err_clr", err, 0);
      check("inv_ready", cmd_ready, 1);
      reg_check("inv_r2", 2'd2, 8'hFF);
      reg_check("inv_r0", 2'd0, 8'h05);
      check("inv_flags", flags, 4'b1010);

      // back-to-back AND/OR/XOR with cmd_valid held; XOR depends on both earlier results
      load(2'd0, 8'hF0);
      load(2'd1, 8'h3C);
      k = 0;
      cyc = 0;
      cmd_valid = 1'b1;
      cmd_op = q_op[0]; cmd_ra = q_ra[0]; cmd_rb = q_rb[0]; cmd_rd = q_rd[0];
      while (k < 3 && cyc < 40) begin
         if (cmd_ready) begin
            acc[k] = cyc;
            k++;
            tick();
            if (k < 3) begin
               cmd_op = q_op[k]; cmd_ra = q_ra[k]; cmd_rb = q_rb[k]; cmd_rd = q_rd[k];
            end else cmd_valid = 1'b0;
         end else tick();
         cyc++;
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", k, 3);
      check("b2b_gap1", acc[1] - acc[0], 4);
      check("b2b_gap2", acc[2] - acc[1], 4);
      cyc = 0;
      while (!cmd_ready && cyc < 20) begin
         tick();
         cyc++;
      end
      check("b2b_idle", cmd_ready, 1);
      reg_check("and_r2", 2'd2, 8'h30);
      reg_check("or_r3", 2'd3, 8'hFC);
      reg_check("xor_r0", 2'd0, 8'hCC);
      check("xor_flags", flags, 4'b1000);

      load(2'd0, 8'h80);
      load(2'd1, 8'h01);
      do_cmd(4'd6, 2'd0, 2'd1, 2'd3, 8'h02, 1'b1, 8'h80, IMM_B);
      reg_check("sra_r3", 2'd3, IMM_Y);
      check("sra_flags", flags, 4'b1000);

      // reset during EXEC discards the command
      load(2'd0, 8'h01);
      load(2'd1, 8'h02);
      cmd_valid = 1'b1; cmd_op = 4'd8; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("mid_in_exec", alu_opcode, 4'd8);
      reset = 1'b1;
      tick();
      check("mid_ready", cmd_ready, 1);
      check("mid_done", done, 0);
      check("mid_opcode", alu_opcode, 0);
      check("mid_flags", flags, 0);
      for (int i = 0; i < 4; i++) reg_check("mid_reg", 2'(i), 8'h00);
      reset = 1'b0;
      tick();
      check("mid_no_done", done, 0);
      reg_check("mid_no_wb", 2'd3, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
